// File: rtl/ofdm_preamble_inserter.sv
// Prepends a periodic training preamble to fixed-length payload frames and appends an optional
// zero gap; configured over the settings bus, with a single registered output stage.
module ofdm_preamble_inserter #(
    parameter int MAX_PATTERN_LEN = 64,
    parameter int SR_BASE         = 129
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        sof,
    output logic        busy
);

    localparam int PW = $clog2(MAX_PATTERN_LEN);
    localparam logic [7:0] A_ENABLE = 8'(SR_BASE);
    localparam logic [7:0] A_PLEN   = 8'(SR_BASE + 1);
    localparam logic [7:0] A_PDATA  = 8'(SR_BASE + 2);
    localparam logic [7:0] A_PRE    = 8'(SR_BASE + 3);
    localparam logic [7:0] A_FRAME  = 8'(SR_BASE + 4);
    localparam logic [7:0] A_GAP    = 8'(SR_BASE + 5);

    // state    | meaning
    // S_IDLE   | waiting for the first payload sample, nothing consumed
    // S_PRE    | emitting pattern RAM samples
    // S_PAY    | forwarding FRAME_LEN input samples
    // S_GAP    | emitting zero samples
    // S_BYP    | enable=0, pass-through until i_tlast
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_GAP, S_BYP} state_t;

    logic          enable_q;
    logic [15:0]   pattern_len_q, preamble_len_q, frame_len_q, gap_len_q;
    logic [PW-1:0] wr_ptr_q;
    logic [31:0]   ram_q [MAX_PATTERN_LEN];

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [PW-1:0] pat_idx_q;
    logic [15:0]   pat_len_s_q, pre_len_s_q, frame_len_s_q, gap_len_s_q;
    logic          sof_pend_q;
    logic [31:0]   o_tdata_q;
    logic          o_tlast_q, o_tvalid_q, sof_q;

    logic          adv;
    logic [15:0]   pat_len_eff;
    logic          pay_last;

    assign adv         = !o_tvalid_q || o_tready;
    assign pat_len_eff = (pattern_len_q == 16'd0 || pattern_len_q > 16'(MAX_PATTERN_LEN))
                         ? 16'(MAX_PATTERN_LEN) : pattern_len_q;
    assign pay_last    = (cnt_q == frame_len_s_q - 16'd1);

    assign i_tready = ((state_q == S_PAY) || (state_q == S_BYP)) && adv;
    assign busy     = (state_q != S_IDLE);
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign sof      = sof_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q       <= 1'b1;
            pattern_len_q  <= 16'd16;
            preamble_len_q <= 16'd160;
            frame_len_q    <= 16'd1024;
            gap_len_q      <= 16'd0;
            wr_ptr_q       <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
        end else if (set_stb) begin
            case (set_addr)
                A_ENABLE: enable_q <= set_data[0];
                A_PLEN: begin
                    pattern_len_q <= set_data[15:0];
                    wr_ptr_q      <= '0;
                end
                A_PDATA:  wr_ptr_q       <= wr_ptr_q + PW'(1);
                A_PRE:    preamble_len_q <= set_data[15:0];
                A_FRAME:  frame_len_q    <= set_data[15:0];
                A_GAP:    gap_len_q      <= set_data[15:0];
                default: begin end
            endcase
        end
    end

    // Pattern storage has no reset; firmware loads it before use.
    always_ff @(posedge clk) begin
        if (set_stb && !clear && set_addr == A_PDATA)
            ram_q[wr_ptr_q] <= set_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pat_idx_q     <= '0;
            pat_len_s_q   <= 16'd16;
            pre_len_s_q   <= 16'd160;
            frame_len_s_q <= 16'd1024;
            gap_len_s_q   <= 16'd0;
            sof_pend_q    <= 1'b0;
            o_tdata_q     <= '0;
            o_tlast_q     <= 1'b0;
            o_tvalid_q    <= 1'b0;
            sof_q         <= 1'b0;
        end else if (clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_idx_q  <= '0;
            sof_pend_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
            sof_q      <= 1'b0;
        end else begin
            if (adv) begin
                o_tvalid_q <= 1'b0;
                o_tlast_q  <= 1'b0;
                sof_q      <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_tvalid) begin
                        pat_len_s_q   <= pat_len_eff;
                        pre_len_s_q   <= preamble_len_q;
                        frame_len_s_q <= (frame_len_q == 16'd0) ? 16'd1 : frame_len_q;
                        gap_len_s_q   <= gap_len_q;
                        cnt_q         <= '0;
                        pat_idx_q     <= '0;
                        sof_pend_q    <= enable_q;
                        if (!enable_q)
                            state_q <= S_BYP;
                        else if (preamble_len_q == 16'd0)
                            state_q <= S_PAY;
                        else
                            state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (adv) begin
                        o_tvalid_q <= 1'b1;
                        o_tdata_q  <= ram_q[pat_idx_q];
                        sof_q      <= sof_pend_q;
                        sof_pend_q <= 1'b0;
                        pat_idx_q  <= (16'(pat_idx_q) == pat_len_s_q - 16'd1) ? '0 : pat_idx_q + PW'(1);
                        if (cnt_q == pre_len_s_q - 16'd1) begin
                            cnt_q   <= '0;
                            state_q <= S_PAY;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (adv && i_tvalid) begin
                        o_tvalid_q <= 1'b1;
                        o_tdata_q  <= i_tdata;
                        o_tlast_q  <= pay_last && (gap_len_s_q == 16'd0);
                        sof_q      <= sof_pend_q;
                        sof_pend_q <= 1'b0;
                        if (pay_last) begin
                            cnt_q   <= '0;
                            state_q <= (gap_len_s_q == 16'd0) ? S_IDLE : S_GAP;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (adv) begin
                        o_tvalid_q <= 1'b1;
                        o_tdata_q  <= '0;
                        o_tlast_q  <= (cnt_q == gap_len_s_q - 16'd1);
                        if (cnt_q == gap_len_s_q - 16'd1) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                S_BYP: begin
                    if (adv && i_tvalid) begin
                        o_tvalid_q <= 1'b1;
                        o_tdata_q  <= i_tdata;
                        o_tlast_q  <= i_tlast;
                        if (i_tlast)
                            state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_preamble_inserter.sv
// Bench for ofdm_preamble_inserter: random payloads and stalls checked against a frame-level
// model that builds each expected output packet from the register settings.
module tb_ofdm_preamble_inserter;

    localparam int SRB = 129;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        sof;
    logic        busy;

    ofdm_preamble_inserter dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sof(sof), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic sof; logic last; logic [31:0] data; } beat_t;
    typedef struct packed { logic last; logic [31:0] data; } in_t;

    int    total = 0;
    int    bad = 0;
    int    stall_err = 0;
    bit    feed_rand = 0;
    bit    rdy_rand = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    in_t   feed_q[$];

    // reference model of the register file and pattern RAM
    int          m_en = 1, m_patlen = 16, m_pre = 160, m_frame = 1024, m_gap = 0, m_ptr = 0;
    logic [31:0] m_ram [64];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // input feeder, ready randomiser and output monitor
    initial begin : drv
        logic  hs_in;
        logic  prev_stall;
        beat_t prev;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            hs_in = i_tvalid && i_tready;
            if (prev_stall && (!o_tvalid || beat_t'({sof, o_tlast, o_tdata}) != prev))
                stall_err++;
            prev_stall = o_tvalid && !o_tready;
            prev = {sof, o_tlast, o_tdata};
            if (o_tvalid && o_tready)
                obs_q.push_back({sof, o_tlast, o_tdata});
            @(posedge clk);
            #1;
            if (hs_in && feed_q.size() > 0)
                void'(feed_q.pop_front());
            if (feed_q.size() > 0 && (!feed_rand || $urandom_range(1, 0) == 1)) begin
                i_tvalid = 1'b1;
                i_tdata  = feed_q[0].data;
                i_tlast  = feed_q[0].last;
            end else begin
                i_tvalid = 1'b0;
                i_tdata  = $urandom;
                i_tlast  = 1'b0;
            end
            o_tready = !rdy_rand || ($urandom_range(1, 0) == 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = 8'(SRB + off); set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
        case (off)
            0: m_en = int'(d[0]);
            1: begin m_patlen = int'(d[15:0]); m_ptr = 0; end
            2: begin m_ram[m_ptr] = d; m_ptr = (m_ptr + 1) % 64; end
            3: m_pre = int'(d[15:0]);
            4: m_frame = int'(d[15:0]);
            5: m_gap = int'(d[15:0]);
            default: ;
        endcase
    endtask

    // Builds the expected packet: preamble, payload, gap, from the current model settings.
    task automatic start_frame(input int npay);
        int pl, fr;
        in_t v;
        beat_t b;
        pl = (m_patlen == 0 || m_patlen > 64) ? 64 : m_patlen;
        fr = (m_frame == 0) ? 1 : m_frame;
        exp_q.delete();
        obs_q.delete();
        for (int n = 0; n < m_pre; n++) begin
            b.sof = (n == 0); b.last = 1'b0; b.data = m_ram[n % pl];
            exp_q.push_back(b);
        end
        for (int k = 0; k < npay; k++) begin
            v.last = 1'b0; v.data = $urandom;
            feed_q.push_back(v);
            if (k < fr) begin
                b.sof = (m_pre == 0 && k == 0); b.last = (k == fr - 1 && m_gap == 0); b.data = v.data;
                exp_q.push_back(b);
            end
        end
        for (int g = 0; g < m_gap; g++) begin
            b.sof = 1'b0; b.last = (g == m_gap - 1); b.data = '0;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_and_check(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (obs_q.size() < exp_q.size() && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({tag, " beat count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < obs_q.size())
                chk($sformatf("%s beat %0d", tag, i + 1), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    initial begin : main
        in_t   v;
        beat_t b;
        int    cyc;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst o_tvalid", 64'(o_tvalid), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst i_tready", 64'(i_tready), 64'(0));
        chk("rst sof", 64'(sof), 64'(0));
        chk("rst o_tlast", 64'(o_tlast), 64'(0));
        reset_n = 1'b1;

        // basic frame: 10 pattern repeats, 8 payload, 4 zeros
        wr(1, 16);
        for (int k = 0; k < 16; k++) wr(2, {16'(k), ~16'(k)});
        wr(3, 160); wr(4, 8); wr(5, 4);
        start_frame(8);
        wait_and_check("t1", 2000);
        chk("t1 busy after", 64'(busy), 64'(0));

        // same frame under random backpressure and input gaps
        feed_rand = 1; rdy_rand = 1;
        start_frame(8);
        wait_and_check("t2", 5000);
        chk("t2 stall stability", 64'(stall_err), 64'(0));
        feed_rand = 0; rdy_rand = 0;

        // no preamble, no gap
        wr(3, 0); wr(5, 0); wr(4, 4);
        start_frame(4);
        wait_and_check("t3", 500);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3 i_tready idle", 64'(i_tready), 64'(0));
        end

        // partial pattern repeat, mid-frame FRAME_LEN write applies to the next frame
        wr(3, 20); wr(4, 8);
        start_frame(8);
        cyc = 0;
        while (!busy && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t4 started", 64'(busy), 64'(1));
        wr(4, 32);
        wait_and_check("t4a", 500);
        start_frame(32);
        wait_and_check("t4b", 500);

        // bypass
        wr(0, 0);
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 3; k++) begin
            v.last = (k == 2); v.data = $urandom;
            feed_q.push_back(v);
            b.sof = 1'b0; b.last = v.last; b.data = v.data;
            exp_q.push_back(b);
        end
        wait_and_check("t5", 500);
        chk("t5 busy after", 64'(busy), 64'(0));
        wr(0, 1);

        // soft clear mid-preamble; the pattern pointer must return to 0
        wr(3, 20); wr(4, 8); wr(5, 0);
        start_frame(8);
        cyc = 0;
        while (obs_q.size() < 5 && cyc < 100) begin @(negedge clk); cyc++; end
        @(posedge clk); #1;
        clear = 1'b1;
        feed_q.delete();
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr o_tvalid", 64'(o_tvalid), 64'(0));
        chk("clr busy", 64'(busy), 64'(0));
        m_ptr = 0;
        wr(2, 32'hA5A5_5A5A);
        wr(1, 16);
        wr(3, 3); wr(4, 2);
        start_frame(2);
        wait_and_check("t7", 500);

        // asynchronous reset during payload
        wr(3, 4); wr(4, 8); wr(5, 0);
        start_frame(8);
        cyc = 0;
        while (obs_q.size() < 7 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6 in payload", 64'(o_tvalid), 64'(1));
        #1;
        reset_n = 1'b0;
        feed_q.delete();
        #1;
        chk("t6 rst o_tvalid", 64'(o_tvalid), 64'(0));
        chk("t6 rst o_tlast", 64'(o_tlast), 64'(0));
        chk("t6 rst sof", 64'(sof), 64'(0));
        chk("t6 rst busy", 64'(busy), 64'(0));
        chk("t6 rst i_tready", 64'(i_tready), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_en = 1; m_patlen = 16; m_pre = 160; m_frame = 1024; m_gap = 0; m_ptr = 0;
        start_frame(1024);
        wait_and_check("t6 defaults", 4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
